// File: rtl/filter_sched_pkg.sv
// filter_sched_pkg
// Shared constants and types for the filter scheduler.
//   NCH_DEF   - default number of channels sharing the filter engine
//   DEPTH_DEF - default number of equal granted samples needed to flip an output
//   CH_W      - channel index width for the default channel count
//   ch_idx_t  - channel index type for the default channel count
//   idx_w()   - index width for an arbitrary channel count (at least 1 bit)
package filter_sched_pkg;

    localparam int NCH_DEF   = 4;
    localparam int DEPTH_DEF = 3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W = idx_w(NCH_DEF);

    typedef logic [CH_W-1:0] ch_idx_t;

endpackage

// File: rtl/filter_sched_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin selection: the first set request at or after the
// pointer, wrapping modulo NCH.
//   i_req   [NCH-1:0]  per-channel requests
//   i_ptr   [IW-1:0]   starting channel for this search
//   o_pick  [NCH-1:0]  one-hot selected channel, zero if no request
//   o_idx   [IW-1:0]   index of the selected channel, zero if no request
//   o_valid            any request present
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] i_req,
    input  logic [IW-1:0]  i_ptr,
    output logic [NCH-1:0] o_pick,
    output logic [IW-1:0]  o_idx,
    output logic           o_valid
);

    int w_k;

    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = 0;
        for (int i = 0; i < NCH; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= NCH) w_k = w_k - NCH;
            if (!o_valid && i_req[w_k]) begin
                o_valid     = 1'b1;
                o_pick[w_k] = 1'b1;
                o_idx       = IW'(w_k);
            end
        end
    end

endmodule

// File: rtl/filter_sched.sv
// filter_sched
// One shared glitch filter time-multiplexed over NCH channels. Each edge a
// round-robin arbiter picks one requesting channel; its raw level is shifted
// into that channel's DEPTH-bit history and the filtered output flips once
// DEPTH consecutive granted samples agree. Unserviced channels keep their
// history and output frozen.
//   clock                 rising-edge clock
//   reset                 synchronous active-low reset
//   sig_in   [NCH-1:0]    raw channel levels
//   req      [NCH-1:0]    per-channel service request
//   grant    [NCH-1:0]    registered one-hot of the channel serviced last edge
//   sig_out  [NCH-1:0]    registered filtered levels
//   evt_valid             one-cycle pulse on any sig_out change (FILTER_SCHED_EVT_EN)
//   evt_ch                index of the changed channel (FILTER_SCHED_EVT_EN)
// Optional feature macro: FILTER_SCHED_EVT_EN adds the change-event outputs.
module filter_sched
    import filter_sched_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NCH-1:0]         sig_in,
    input  logic [NCH-1:0]         req,
    output logic [NCH-1:0]         grant,
`ifdef FILTER_SCHED_EVT_EN
    output logic [NCH-1:0]         sig_out,
    output logic                   evt_valid,
    output logic [idx_w(NCH)-1:0]  evt_ch
`else
    output logic [NCH-1:0]         sig_out
`endif
);

    localparam int IW = idx_w(NCH);

    logic [IW-1:0]    r_ptr;
    logic [NCH-1:0]   r_grant;
    logic [NCH-1:0]   r_sig_out;
    logic [DEPTH-1:0] r_hist [NCH];

    logic [NCH-1:0]   w_pick;
    logic [IW-1:0]    w_idx;
    logic             w_valid;
    logic [DEPTH-1:0] w_hist_new;
    logic             w_change;

    rr_arbiter #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // Shift-left form keeps DEPTH == 1 legal (no zero-width slice).
    always_comb begin
        w_hist_new = (r_hist[w_idx] << 1) | DEPTH'(sig_in[w_idx]);
        w_change   = w_valid
                   && ((w_hist_new == '0) || (w_hist_new == '1))
                   && (w_hist_new[0] != r_sig_out[w_idx]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_grant   <= '0;
            r_sig_out <= '0;
            for (int c = 0; c < NCH; c++) r_hist[c] <= '0;
        end else begin
            r_grant <= w_pick;
            if (w_valid) begin
                r_hist[w_idx] <= w_hist_new;
                r_ptr         <= (w_idx == IW'(NCH - 1)) ? '0 : IW'(w_idx + 1'b1);
                if (w_change) r_sig_out[w_idx] <= w_hist_new[0];
            end
        end
    end

    assign grant   = r_grant;
    assign sig_out = r_sig_out;

`ifdef FILTER_SCHED_EVT_EN
    logic          r_evt_valid;
    logic [IW-1:0] r_evt_ch;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
        end else begin
            r_evt_valid <= w_change;
            if (w_change) r_evt_ch <= w_idx;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_ch    = r_evt_ch;
`endif

endmodule

// File: tb/tb_filter_sched.sv
module tb_filter_sched;
    import filter_sched_pkg::*;

    logic       clock;
    logic       reset;
    logic [3:0] sig_in;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] sig_out;
`ifdef FILTER_SCHED_EVT_EN
    logic       evt_valid;
    ch_idx_t    evt_ch;
`endif

    int n_chk;
    int n_err;

    filter_sched #(
        .NCH   (4),
        .DEPTH (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sig_in    (sig_in),
        .req       (req),
        .grant     (grant),
`ifdef FILTER_SCHED_EVT_EN
        .sig_out   (sig_out),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch)
`else
        .sig_out   (sig_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    logic [3:0] rr_exp [8];
    logic [1:0] glitch [6];

    initial begin
        n_chk  = 0;
        n_err  = 0;
        reset  = 1'b0;
        sig_in = 4'b1111;
        req    = 4'b1111;

        // reset dominates active inputs
        cyc();
        chk("rst_sig_out", 32'(sig_out), 32'h0);
        chk("rst_grant",   32'(grant),   32'h0);
`ifdef FILTER_SCHED_EVT_EN
        chk("rst_evt",     32'(evt_valid), 32'h0);
`endif
        reset = 1'b1;

        // single channel: rises on the 3rd granted sample
        req    = 4'b0001;
        sig_in = 4'b0001;
        for (int e = 1; e <= 4; e++) begin
            cyc();
            chk($sformatf("single_grant_e%0d", e), 32'(grant), 32'h1);
            chk($sformatf("single_out_e%0d", e), 32'(sig_out), (e >= 3) ? 32'h1 : 32'h0);
`ifdef FILTER_SCHED_EVT_EN
            chk($sformatf("single_evt_e%0d", e), 32'(evt_valid), (e == 3) ? 32'h1 : 32'h0);
            if (e == 3) chk("single_evt_ch", 32'(evt_ch), 32'h0);
`endif
        end

        // glitch: 1,1,0,1,1,1 -> rise only at edge 6
        do_reset();
        chk("rst2_sig_out", 32'(sig_out), 32'h0);
        glitch[0] = 2'd1; glitch[1] = 2'd1; glitch[2] = 2'd0;
        glitch[3] = 2'd1; glitch[4] = 2'd1; glitch[5] = 2'd1;
        req = 4'b0001;
        for (int e = 0; e < 6; e++) begin
            sig_in = {3'b000, glitch[e][0]};
            cyc();
            chk($sformatf("glitch_out_e%0d", e + 1), 32'(sig_out), (e == 5) ? 32'h1 : 32'h0);
        end

        // round-robin order, req change, idle hold of pointer
        do_reset();
        sig_in = 4'b0000;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001; rr_exp[5] = 4'b0010;
        rr_exp[6] = 4'b1000; rr_exp[7] = 4'b0010;
        for (int e = 0; e < 8; e++) begin
            req = (e < 5) ? 4'b1111 : 4'b1010;
            cyc();
            chk($sformatf("rr_grant_%0d", e), 32'(grant), 32'(rr_exp[e]));
        end
        req = 4'b0000;
        cyc();
        chk("rr_idle_grant", 32'(grant), 32'h0);
        req = 4'b1111;
        cyc();
        chk("rr_ptr_held", 32'(grant), 32'b0100);

        // freeze: build hist[2]=011, idle 5 cycles, then one granted 1 flips it
        do_reset();
        req = 4'b0100;
        sig_in = 4'b0000; cyc();
        sig_in = 4'b0100; cyc();
        cyc();
        chk("frz_pre_out", 32'(sig_out), 32'h0);
        req    = 4'b0000;
        sig_in = 4'b0000;
        for (int e = 0; e < 5; e++) begin
            cyc();
            chk($sformatf("frz_idle_grant_%0d", e), 32'(grant), 32'h0);
        end
        chk("frz_idle_out", 32'(sig_out), 32'h0);
        req    = 4'b0100;
        sig_in = 4'b0100;
        cyc();
        chk("frz_grant", 32'(grant), 32'b0100);
        chk("frz_out",   32'(sig_out), 32'b0100);
`ifdef FILTER_SCHED_EVT_EN
        chk("frz_evt",    32'(evt_valid), 32'h1);
        chk("frz_evt_ch", 32'(evt_ch), 32'h2);
`endif

        // mid-operation reset: reach sig_out=0101 (ptr=3 here; ch0 third grant at edge 10)
        req    = 4'b1111;
        sig_in = 4'b0101;
        for (int e = 0; e < 10; e++) cyc();
        chk("mid_pre_out", 32'(sig_out), 32'b0101);
        do_reset();
        chk("mid_rst_out",   32'(sig_out), 32'h0);
        chk("mid_rst_grant", 32'(grant),   32'h0);
        sig_in = 4'b0000;
        cyc();
        chk("mid_first_grant", 32'(grant), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
